// File: rtl/zsy_spi_rx_byte.sv
// zsy_spi_rx_byte: oversampling SPI byte receiver reporting MSB-first bytes with their D/C flag
module zsy_spi_rx_byte #(
  parameter logic SCLK_IDLE   = 1'b1,
  parameter logic SAMPLE_RISE = 1'b1,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             dc,
  input  logic             sdin,
  output logic [7:0]       rxByte,
  output logic             rx_dc,
  output logic             isDone,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_bytes
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [CNT_W-1:0] FB_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, dc_sync, sdin_sync;
  logic                   sclk_q;
  logic                   cs_s, sclk_s, dc_s, sdin_s, act_edge;
  state_t                 state, state_n;
  logic [2:0]             cnt;
  logic [7:0]             sr;
  logic                   dc_cap;
  logic                   start, shift_en, err_set, done_set;
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync[SYNC_STAGES-1];
  assign act_edge = SAMPLE_RISE ? (sclk_s & ~sclk_q) : (~sclk_s & sclk_q);
  // input synchronisers, all the same depth so dc/sdin stay aligned with sclk, plus the sclk edge register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      dc_sync   <= '0;
      sdin_sync <= '0;
      sclk_q    <= SCLK_IDLE;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      sclk_q    <= sclk_s;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next state: an 8th edge wins over a simultaneous cs_n rise so the byte is still delivered
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = cs_s ? IDLE : SHIFT;
    else if (state == SHIFT) state_n = (act_edge && cnt == 3'd7) ? DONE : (cs_s ? IDLE : SHIFT);
    else state_n = cs_s ? IDLE : SHIFT;
  end
  // state-decoded controls; a partial byte at cs_n rise is an error unless the edge completes it
  always_comb begin
    busy     = state != IDLE;
    start    = state == IDLE && !cs_s;
    shift_en = act_edge && state != IDLE;
    done_set = state == DONE;
    err_set  = state == SHIFT && cs_s && !(act_edge && cnt == 3'd7) && (cnt != 3'd0 || act_edge);
  end
  // deserialiser; also shifts in DONE so an edge landing there becomes bit 7 of the next byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      sr     <= 8'd0;
      dc_cap <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= 3'd0;
      sr  <= 8'd0;
    end else if (shift_en) begin
      sr     <= {sr[6:0], sdin_s};
      cnt    <= cnt + 3'd1;
      dc_cap <= dc_s;
    end
  end
  // registered results and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxByte      <= 8'd0;
      rx_dc       <= 1'b0;
      isDone      <= 1'b0;
      frame_err   <= 1'b0;
      frame_bytes <= '0;
    end else begin
      isDone    <= done_set;
      frame_err <= err_set;
      if (done_set) begin
        rxByte      <= sr;
        rx_dc       <= dc_cap;
        frame_bytes <= (&frame_bytes) ? frame_bytes : frame_bytes + FB_ONE;
      end else if (start) begin
        frame_bytes <= '0;
      end
    end
  end
endmodule
